// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 states, command/response codes and parity helper
package ps2_pkg;

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE} state_t;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] RSP_ACK     = 8'hFA;
    localparam logic [7:0] RSP_INIT    = 8'hAA;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: synchronizes PS/2 lines, debounces the clock and flags its falling edges
module ps2_line_filter #(
    parameter int FILTER_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_raw,
    input  logic data_raw,
    output logic clk_sync,
    output logic data_sync,
    output logic fall
);
    localparam int CW = $clog2(FILTER_CYCLES + 1);

    logic [1:0]    clk_ff;
    logic [1:0]    data_ff;
    logic [CW-1:0] cnt;
    logic          clk_filt;

    assign clk_sync  = clk_ff[1];
    assign data_sync = data_ff[1];

    // two-stage synchronizers; idle bus lines sit high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_ff  <= 2'b11;
            data_ff <= 2'b11;
        end else begin
            clk_ff  <= {clk_ff[0], clk_raw};
            data_ff <= {data_ff[0], data_raw};
        end
    end

    // filtered clock follows only after a run of disagreeing samples; fall marks a 1->0 flip
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            clk_filt <= 1'b1;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_sync == clk_filt) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_CYCLES - 1)) begin
                cnt      <= '0;
                clk_filt <= clk_sync;
                fall     <= clk_filt;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one host-to-device PS/2 command byte and checks the device ACK
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic       busy,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);
    localparam logic [31:0] INH_LAST = 32'(INHIBIT_CYCLES - 1);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      state, state_n;
    logic [8:0]  frame, frame_n;
    logic [3:0]  bit_cnt, bit_cnt_n;
    logic [31:0] cnt, cnt_n;
    logic        err_flag, err_flag_n;
    logic        data_q, data_n;
    logic        done_n, err_n;
    logic        clk_sync, data_sync, fall;

    ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filter (
        .clk      (clk),
        .rst      (rst),
        .clk_raw  (ps2_clk_i),
        .data_raw (ps2_data_i),
        .clk_sync (clk_sync),
        .data_sync(data_sync),
        .fall     (fall)
    );

    assign tx_ready    = state == IDLE;
    assign busy        = state != IDLE;
    assign ps2_clk_oe  = state == INHIBIT;
    // the start bit is already driven during the final inhibit cycle
    assign ps2_data_oe = data_q | (state == INHIBIT && cnt == INH_LAST);

    // state and datapath registers; reset releases both lines at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            frame    <= '0;
            bit_cnt  <= '0;
            cnt      <= '0;
            err_flag <= 1'b0;
            data_q   <= 1'b0;
            tx_done  <= 1'b0;
            tx_err   <= 1'b0;
        end else begin
            state    <= state_n;
            frame    <= frame_n;
            bit_cnt  <= bit_cnt_n;
            cnt      <= cnt_n;
            err_flag <= err_flag_n;
            data_q   <= data_n;
            tx_done  <= done_n;
            tx_err   <= err_n;
        end
    end

    // next state: frame bits shift out on device clock falls, 1s fill in behind for the stop bit
    always_comb begin
        state_n    = state;
        frame_n    = frame;
        bit_cnt_n  = bit_cnt;
        cnt_n      = cnt;
        err_flag_n = err_flag;
        data_n     = data_q;
        done_n     = 1'b0;
        err_n      = 1'b0;
        case (state)
            IDLE: begin
                if (tx_start) begin
                    frame_n    = {odd_parity(tx_data), tx_data};
                    bit_cnt_n  = '0;
                    cnt_n      = '0;
                    err_flag_n = 1'b0;
                    state_n    = INHIBIT;
                end
            end
            INHIBIT: begin
                cnt_n = cnt + 32'd1;
                if (cnt == INH_LAST) begin
                    cnt_n   = '0;
                    data_n  = 1'b1;
                    state_n = REQ;
                end
            end
            REQ, SHIFT, ACK: begin
                cnt_n = cnt + 32'd1;
                if (cnt == TMO_LAST) begin
                    err_n   = 1'b1;
                    data_n  = 1'b0;
                    state_n = IDLE;
                end else if (fall) begin
                    if (state == ACK) begin
                        err_n      = data_sync;
                        err_flag_n = data_sync;
                        state_n    = WAIT_IDLE;
                    end else begin
                        data_n    = ~frame[0];
                        frame_n   = {1'b1, frame[8:1]};
                        bit_cnt_n = bit_cnt + 4'd1;
                        state_n   = (state == SHIFT && bit_cnt == 4'd9) ? ACK : SHIFT;
                    end
                end
            end
            WAIT_IDLE: begin
                if (clk_sync && data_sync) begin
                    done_n  = ~err_flag;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized PS/2 device model against a frame-level reference
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 300;
    localparam int TMO  = 6000;
    localparam int FLT  = 4;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_ready, tx_done, tx_err, busy, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       line_clk, line_data;

    assign line_clk  = dev_clk & ~ps2_clk_oe;
    assign line_data = dev_data & ~ps2_data_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILTER_CYCLES(FLT)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_ready   (tx_ready),
        .tx_done    (tx_done),
        .tx_err     (tx_err),
        .busy       (busy),
        .ps2_clk_i  (line_clk),
        .ps2_data_i (line_data),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, busy_done = 0;
    int inh_run = 0, ovl_run = 0, inh_len = 0, inh_ovl = 0, req_cyc = 0, err_cyc = 0;

    // bus monitor: completion pulses, inhibit length, start-bit overlap, request entry
    always @(negedge clk) begin
        cyc++;
        done_cnt += int'(tx_done);
        err_cnt  += int'(tx_err);
        if (tx_done && tx_err) both_cnt++;
        if (tx_done && busy) busy_done++;
        if (tx_err) err_cyc = cyc;
        if (ps2_clk_oe) begin
            inh_run++;
            ovl_run += int'(ps2_data_oe);
        end else if (inh_run != 0) begin
            inh_len = inh_run;
            inh_ovl = ovl_run;
            inh_run = 0;
            ovl_run = 0;
            req_cyc = cyc;
        end
    end

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // bits the device should see: start, d0..d7, odd parity, stop
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        int ones = 0;
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = ((d >> i) & 8'd1) != 0;
            ones += ((d >> i) & 8'd1) != 0 ? 1 : 0;
        end
        f[9]  = (ones % 2) == 0;
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic device(input bit ack, input int poke_at, input int abort_at,
                          output logic [10:0] got, output bit aborted);
        int t = 0;
        got = '1;
        aborted = 1'b0;
        while (!(line_data == 1'b0 && ps2_clk_oe == 1'b0) && t < 20000) begin
            tk(1);
            t++;
        end
        check("req_seen", 32'(t < 20000), 1);
        if (t >= 20000) return;
        got[0] = line_data;
        tk(HALF);
        for (int k = 1; k <= 10; k++) begin
            dev_clk = 1'b0;
            tk(HALF / 2);
            if (k == poke_at) begin
                tx_data  = 8'h00;
                tx_start = 1'b1;
                tk(1);
                tx_start = 1'b0;
            end
            if (k == abort_at) begin
                rst = 1'b0;
                #1;
                check("rst_clk_oe", ps2_clk_oe, 0);
                check("rst_data_oe", ps2_data_oe, 0);
                tk(1);
                rst = 1'b1;
                dev_clk = 1'b1;
                aborted = 1'b1;
                return;
            end
            tk(HALF / 2);
            dev_clk = 1'b1;
            got[k] = line_data;
            tk(HALF);
        end
        if (ack) dev_data = 1'b0;
        tk(4);
        dev_clk = 1'b0;
        tk(HALF);
        dev_clk = 1'b1;
        tk(4);
        dev_data = 1'b1;
    endtask

    task automatic send(input logic [7:0] d, input bit ack, input int poke_at,
                        input int abort_at, input string tag);
        int d0 = done_cnt;
        int e0 = err_cnt;
        int t = 0;
        logic [10:0] got;
        bit ab;
        while (!tx_ready && t < 1000) begin
            tk(1);
            t++;
        end
        check({tag, "_ready_in"}, tx_ready, 1);
        tx_data  = d;
        tx_start = 1'b1;
        tk(1);
        tx_start = 1'b0;
        tx_data  = 8'($urandom);
        device(ack, poke_at, abort_at, got, ab);
        if (ab) begin
            tk(5);
            check({tag, "_ready_after_rst"}, tx_ready, 1);
            check({tag, "_no_pulse"}, 32'(done_cnt - d0 + err_cnt - e0), 0);
            return;
        end
        check({tag, "_frame"}, 32'(got), 32'(model_frame(d)));
        check({tag, "_inhibit_len"}, inh_len, INH);
        check({tag, "_start_overlap"}, inh_ovl, 1);
        t = 0;
        while (done_cnt == d0 && err_cnt == e0 && t < 2000) begin
            tk(1);
            t++;
        end
        tk(10);
        check({tag, "_done_cnt"}, 32'(done_cnt - d0), ack ? 1 : 0);
        check({tag, "_err_cnt"}, 32'(err_cnt - e0), ack ? 0 : 1);
        check({tag, "_oe_released"}, {ps2_clk_oe, ps2_data_oe}, 0);
        check({tag, "_ready_out"}, tx_ready, 1);
    endtask

    initial begin
        int d0, e0, t;
        tk(3);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        check("rst_pulses", {tx_done, tx_err}, 0);
        rst = 1'b1;
        tk(2);

        send(CMD_SET_LED, 1'b1, 0, 0, "led");
        send(8'h01, 1'b1, 0, 0, "b01");
        send(CMD_RESET, 1'b1, 0, 0, "bff");
        send(8'($urandom), 1'b0, 0, 0, "nack");

        // device never clocks: timeout measured from request entry
        d0 = done_cnt;
        e0 = err_cnt;
        tx_data  = 8'($urandom);
        tx_start = 1'b1;
        tk(1);
        tx_start = 1'b0;
        t = 0;
        while (err_cnt == e0 && done_cnt == d0 && t < INH + TMO + 200) begin
            tk(1);
            t++;
        end
        tk(2);
        check("tmo_err_cnt", 32'(err_cnt - e0), 1);
        check("tmo_done_cnt", 32'(done_cnt - d0), 0);
        check("tmo_latency", 32'(err_cyc - req_cyc), TMO);
        check("tmo_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        check("tmo_ready", tx_ready, 1);

        send(8'h3C, 1'b1, 0, 5, "abort");
        send(CMD_ENABLE, 1'b1, 0, 0, "enable");
        send(8'hA5, 1'b1, 3, 0, "poke");
        for (int i = 0; i < 4; i++) send(8'($urandom), $urandom_range(0, 3) != 0, 0, 0, "rand");

        check("never_both", both_cnt, 0);
        check("busy_low_at_done", busy_done, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
